// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module   : imm_encoder
// Purpose  : Inverse of the RV32I immediate-extend stage. Packs a 32-bit
//            immediate into the instruction bit positions selected by immSrc,
//            merges it with a base word that carries the opcode, funct and
//            register fields, and queues the result in a small output FIFO.
//            Valid/ready handshake on both sides.
// Optional : `define IMM_ENC_CHECK_EN enables the immediate range check. Each
//            FIFO entry then carries an error flag (out_err), and err_cnt
//            counts accepted erroneous words, saturating. Without the macro,
//            out_err and err_cnt are constant zero and packing is unchanged.
// Ports    : clk, rst      - clock (rising edge); asynchronous active-high reset
//            in_valid/in_ready            - input handshake; in_ready is registered
//            immSrc, imm, base            - format select, immediate, base word
//            out_valid/out_ready/out_instr - output handshake and FIFO head word
//            out_err       - head entry failed the range check
//            err_cnt       - saturating count of accepted erroneous words
// Revision : 1.0 - initial release
// ============================================================================
module imm_encoder #(
    parameter int FIFO_DEPTH = 2,   // power of two, >= 2
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           immSrc,
    input  logic [31:0]          imm,
    input  logic [31:0]          base,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_instr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int C_PTR_W = $clog2(FIFO_DEPTH);
    localparam int C_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [C_CNT_W-1:0] C_DEPTH = C_CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] C_SRC_I = 3'b000;
    localparam logic [2:0] C_SRC_S = 3'b001;
    localparam logic [2:0] C_SRC_B = 3'b010;
    localparam logic [2:0] C_SRC_J = 3'b011;
    localparam logic [2:0] C_SRC_U = 3'b100;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [C_CNT_W-1:0] count_q, count_d;
    logic [C_PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic               in_ready_q;
    logic [31:0]        instr_mem_q [FIFO_DEPTH];
    // Last popped word: keeps out_instr stable while the FIFO is empty
    logic [31:0]        last_instr_q;

    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_packed;

    assign w_push    = in_valid & in_ready_q;
    assign w_pop     = (count_q != '0) & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != '0);
    assign out_instr = (count_q != '0) ? instr_mem_q[rd_ptr_q] : last_instr_q;

    // ------------------------------------------------------------------
    // Immediate packing; bits not owned by the format come from base
    // ------------------------------------------------------------------
    always_comb begin
        w_packed = base;
        case (immSrc)
            C_SRC_I: w_packed = {imm[11:0], base[19:0]};
            C_SRC_S: w_packed = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
            C_SRC_B: w_packed = {imm[12], imm[10:5], base[24:12], imm[4:1],
                                 imm[11], base[6:0]};
            C_SRC_J: w_packed = {imm[20], imm[10:1], imm[11], imm[19:12],
                                 base[11:0]};
            C_SRC_U: w_packed = {imm[31:12], base[11:0]};
            default: w_packed = base;
        endcase
    end

    // ------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            in_ready_q   <= 1'b1;
            last_instr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            // Registered from the next count so out_ready has no path to in_ready
            in_ready_q <= (count_d < C_DEPTH);
            if (w_push) begin
                instr_mem_q[wr_ptr_q] <= w_packed;
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                last_instr_q <= instr_mem_q[rd_ptr_q];
                rd_ptr_q     <= rd_ptr_q + 1'b1;
            end
        end
    end

`ifdef IMM_ENC_CHECK_EN
    // ------------------------------------------------------------------
    // Range check: immediate must be representable in the chosen format
    // ------------------------------------------------------------------
    logic                 w_range_err;
    logic                 err_mem_q [FIFO_DEPTH];
    logic                 last_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_comb begin
        w_range_err = 1'b1;
        case (immSrc)
            // Upper bits must all equal the format's sign bit
            C_SRC_I, C_SRC_S: w_range_err = !((&imm[31:11]) || !(|imm[31:11]));
            C_SRC_B: w_range_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            C_SRC_J: w_range_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            C_SRC_U: w_range_err = (imm[11:0] != 12'h000);
            default: w_range_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_err_q <= 1'b0;
            err_cnt_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                err_mem_q[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                err_mem_q[wr_ptr_q] <= w_range_err;
                if (w_range_err && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
                    err_cnt_q <= err_cnt_q + 1'b1;
                end
            end
            if (w_pop) begin
                last_err_q <= err_mem_q[rd_ptr_q];
            end
        end
    end

    assign out_err = (count_q != '0) ? err_mem_q[rd_ptr_q] : last_err_q;
    assign err_cnt = err_cnt_q;
`else
    assign out_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule
`default_nettype wire
